// File: rtl/axi_slave_mem.sv
// rtl/axi_slave_mem.sv - AXI4 slave memory responder with independent read/write engines
module axi_slave_mem #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 16,
   parameter int ID_W   = 4,
   parameter int DEPTH  = 1024,
   parameter int RD_LAT = 0
) (
   input  logic                aclk,
   input  logic                aresetn,
   input  logic [ID_W-1:0]     awid,
   input  logic [ADDR_W-1:0]   awaddr,
   input  logic [7:0]          awlen,
   input  logic [2:0]          awsize,
   input  logic [1:0]          awburst,
   input  logic                awvalid,
   output logic                awready,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   input  logic                wlast,
   input  logic                wvalid,
   output logic                wready,
   output logic [ID_W-1:0]     bid,
   output logic [1:0]          bresp,
   output logic                bvalid,
   input  logic                bready,
   input  logic [ID_W-1:0]     arid,
   input  logic [ADDR_W-1:0]   araddr,
   input  logic [7:0]          arlen,
   input  logic [2:0]          arsize,
   input  logic [1:0]          arburst,
   input  logic                arvalid,
   output logic                arready,
   output logic [ID_W-1:0]     rid,
   output logic [DATA_W-1:0]   rdata,
   output logic [1:0]          rresp,
   output logic                rlast,
   output logic                rvalid,
   input  logic                rready
);
   localparam int STRB_W = DATA_W / 8;
   localparam int BSHIFT = $clog2(STRB_W);
   localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2;
   localparam logic [1:0] R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2;
   localparam logic [1:0] RESP_OKAY = 2'd0, RESP_SLVERR = 2'd2, RESP_DECERR = 2'd3;

   logic [DATA_W-1:0] mem [DEPTH];

   // WRAP, reserved burst codes and transfers wider than the bus are unsupported
   function automatic logic bad_burst(input logic [2:0] size, input logic [1:0] burst);
      return burst[1] || (int'(size) > BSHIFT);
   endfunction

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] word;
      word = a >> BSHIFT;
      return 64'(word) < 64'(DEPTH);
   endfunction

   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [2:0] size,
                                                  input logic [1:0] burst);
      return (burst == 2'b01) ? a + (ADDR_W'(1) << size) : a;
   endfunction

   // Response codes are ordered by severity, so the numeric maximum is the worst
   function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
      return (a > b) ? a : b;
   endfunction

   // Write engine state
   logic [1:0]        w_state;
   logic [ID_W-1:0]   w_id;
   logic [ADDR_W-1:0] w_addr;
   logic [7:0]        w_len, w_cnt;
   logic [2:0]        w_size;
   logic [1:0]        w_burst, w_err;
   logic              w_bad;

   logic              w_fire, w_last_beat, w_oor, mem_we;
   logic [1:0]        w_beat_err;
   logic [IDX_W-1:0]  w_idx;

   assign awready     = (w_state == W_IDLE);
   assign wready      = (w_state == W_DATA);
   assign bvalid      = (w_state == W_RESP);
   assign w_fire      = wready && wvalid;
   assign w_last_beat = (w_cnt == w_len);
   assign w_oor       = !in_range(w_addr);
   assign w_idx       = IDX_W'(w_addr >> BSHIFT);
   assign mem_we      = w_fire && !w_bad && !w_oor;
   assign w_beat_err  = worst(w_oor ? RESP_DECERR : RESP_OKAY,
                              (w_bad || (wlast != w_last_beat)) ? RESP_SLVERR : RESP_OKAY);

   // Byte-lane memory write; contents deliberately survive reset
   always_ff @(posedge aclk) begin
      if (mem_we) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (wstrb[b]) mem[w_idx][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
   end

   // Write FSM: accept AW, consume len+1 beats, then hold B until bready
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         w_state <= W_IDLE;
         w_id    <= '0;
         w_addr  <= '0;
         w_len   <= '0;
         w_cnt   <= '0;
         w_size  <= '0;
         w_burst <= '0;
         w_err   <= RESP_OKAY;
         w_bad   <= 1'b0;
         bid     <= '0;
         bresp   <= RESP_OKAY;
      end else begin
         case (w_state)
            W_IDLE: if (awvalid) begin
               w_id    <= awid;
               w_addr  <= awaddr;
               w_len   <= awlen;
               w_size  <= awsize;
               w_burst <= awburst;
               w_bad   <= bad_burst(awsize, awburst);
               w_err   <= RESP_OKAY;
               w_cnt   <= 8'd0;
               w_state <= W_DATA;
            end
            W_DATA: if (wvalid) begin
               w_err  <= worst(w_err, w_beat_err);
               w_addr <= next_addr(w_addr, w_size, w_burst);
               w_cnt  <= w_cnt + 8'd1;
               if (w_last_beat) begin
                  bid     <= w_id;
                  bresp   <= worst(w_err, w_beat_err);
                  w_state <= W_RESP;
               end
            end
            W_RESP: if (bready) w_state <= W_IDLE;
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // Read engine state
   logic [1:0]        r_state;
   logic [ID_W-1:0]   r_id;
   logic [ADDR_W-1:0] r_addr;
   logic [7:0]        r_len, r_cnt;
   logic [2:0]        r_size;
   logic [1:0]        r_burst;
   logic              r_bad, r_oor;
   logic [3:0]        lat_cnt;
   logic [1:0]        r_beat_err;
   logic [IDX_W-1:0]  r_idx;

   assign arready    = (r_state == R_IDLE);
   assign r_oor      = !in_range(r_addr);
   assign r_idx      = IDX_W'(r_addr >> BSHIFT);
   assign r_beat_err = worst(r_oor ? RESP_DECERR : RESP_OKAY, r_bad ? RESP_SLVERR : RESP_OKAY);

   // Read FSM: optional latency wait, then back-to-back registered beats
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state <= R_IDLE;
         r_id    <= '0;
         r_addr  <= '0;
         r_len   <= '0;
         r_cnt   <= '0;
         r_size  <= '0;
         r_burst <= '0;
         r_bad   <= 1'b0;
         lat_cnt <= '0;
         rvalid  <= 1'b0;
         rlast   <= 1'b0;
         rid     <= '0;
         rdata   <= '0;
         rresp   <= RESP_OKAY;
      end else begin
         case (r_state)
            R_IDLE: if (arvalid) begin
               r_id    <= arid;
               r_addr  <= araddr;
               r_len   <= arlen;
               r_size  <= arsize;
               r_burst <= arburst;
               r_bad   <= bad_burst(arsize, arburst);
               r_cnt   <= 8'd0;
               lat_cnt <= 4'd0;
               r_state <= (RD_LAT > 0) ? R_WAIT : R_DATA;
            end
            R_WAIT: begin
               if (lat_cnt == 4'(RD_LAT - 1)) r_state <= R_DATA;
               else lat_cnt <= lat_cnt + 4'd1;
            end
            R_DATA: begin
               if (rvalid && rready && rlast) begin
                  rvalid  <= 1'b0;
                  rlast   <= 1'b0;
                  r_state <= R_IDLE;
               end else if (!rvalid || rready) begin
                  rvalid <= 1'b1;
                  rid    <= r_id;
                  rdata  <= (r_bad || r_oor) ? '0 : mem[r_idx];
                  rresp  <= r_beat_err;
                  rlast  <= (r_cnt == r_len);
                  r_cnt  <= r_cnt + 8'd1;
                  r_addr <= next_addr(r_addr, r_size, r_burst);
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_slave_mem.sv
// tb/tb_axi_slave_mem.sv - scoreboard bench for axi_slave_mem
module tb_axi_slave_mem;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 16;
   localparam int ID_W   = 4;
   localparam int DEPTH  = 1024;
   localparam int RD_LAT = 5;

   logic              aclk = 1'b0;
   logic              aresetn;
   logic [ID_W-1:0]   awid, arid, bid, rid;
   logic [ADDR_W-1:0] awaddr, araddr;
   logic [7:0]        awlen, arlen;
   logic [2:0]        awsize, arsize;
   logic [1:0]        awburst, arburst, bresp, rresp;
   logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic              arvalid, arready, rlast, rvalid, rready;
   logic [DATA_W-1:0] wdata, rdata;
   logic [3:0]        wstrb;

   axi_slave_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   always #5 aclk = ~aclk;

   typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } rbeat_t;
   typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;

   rbeat_t r_q[$];
   bexp_t  b_q[$];
   int     checks = 0;
   int     errors = 0;
   int     cyc = 0;
   int     ar_cyc = 0;
   bit     lat_pending = 1'b0;

   always @(posedge aclk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Monitor: compare every presented B and R beat with the queue front
   always @(negedge aclk) begin
      if (aresetn) begin
         if (bvalid && bready) begin
            if (b_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL b_unexpected actual id=%0d resp=%0d required none", bid, bresp);
            end else begin
               bexp_t eb;
               eb = b_q.pop_front();
               chk("bid", 32'(bid), 32'(eb.id));
               chk("bresp", 32'(bresp), 32'(eb.resp));
            end
         end
         if (rvalid) begin
            if (lat_pending) begin
               chk("r_latency", cyc - ar_cyc, RD_LAT + 1);
               lat_pending = 1'b0;
            end
            if (r_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL r_unexpected actual rdata=%h required none", rdata);
            end else begin
               rbeat_t er;
               er = r_q[0];
               chk("rid", 32'(rid), 32'(er.id));
               chk("rdata", rdata, er.data);
               chk("rresp", 32'(rresp), 32'(er.resp));
               chk("rlast", 32'(rlast), 32'(er.last));
               if (rready) void'(r_q.pop_front());
            end
         end
      end
   end

   task automatic wait_drain();
      int n = 0;
      while ((b_q.size() != 0 || r_q.size() != 0) && n < 200) begin
         @(posedge aclk); #1; n++;
      end
      if (n >= 200) begin
         checks++; errors++;
         $display("FAIL drain_timeout actual b=%0d r=%0d pending required 0", b_q.size(), r_q.size());
         b_q.delete(); r_q.delete();
      end
   endtask

   task automatic aw_send(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                          input logic [1:0] burst);
      int n = 0;
      awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
      do begin @(negedge aclk); n++; end while (!awready && n < 50);
      if (!awready) begin checks++; errors++; $display("FAIL aw_timeout actual awready=0 required 1"); end
      @(posedge aclk); #1; awvalid = 1'b0;
   endtask

   task automatic w_send(input logic [31:0] d, input logic [3:0] s, input logic l);
      int n = 0;
      wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
      do begin @(negedge aclk); n++; end while (!wready && n < 50);
      if (!wready) begin checks++; errors++; $display("FAIL w_timeout actual wready=0 required 1"); end
      @(posedge aclk); #1; wvalid = 1'b0;
   endtask

   task automatic ar_send(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                          input logic [1:0] burst);
      int n = 0;
      arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
      do begin @(negedge aclk); n++; end while (!arready && n < 50);
      if (!arready) begin checks++; errors++; $display("FAIL ar_timeout actual arready=0 required 1"); end
      @(posedge aclk); #1; arvalid = 1'b0;
      ar_cyc = cyc; lat_pending = 1'b1;
   endtask

   task automatic do_write(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [31:0] base, input logic [31:0] step,
                           input logic [3:0] strb, input int last_at, input logic [1:0] resp);
      b_q.push_back('{id: id, resp: resp});
      aw_send(id, addr, len, burst);
      for (int i = 0; i <= int'(len); i++) w_send(base + step * i, strb, i == last_at);
      wait_drain();
   endtask

   task automatic push_read(input logic [3:0] id, input logic [7:0] len, input logic [31:0] base,
                            input logic [31:0] step, input logic [1:0] resp);
      for (int i = 0; i <= int'(len); i++)
         r_q.push_back('{id: id, data: base + step * i, resp: resp, last: (i == int'(len))});
   endtask

   task automatic do_read(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [31:0] base, input logic [31:0] step,
                          input logic [1:0] resp);
      push_read(id, len, base, step, resp);
      ar_send(id, addr, len, burst);
      wait_drain();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      aresetn = 1'b0; bready = 1'b1; rready = 1'b1;
      awvalid = 0; wvalid = 0; arvalid = 0;
      awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
      arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0;
      wdata = 0; wstrb = 0; wlast = 0;
      repeat (3) @(negedge aclk);
      chk("rst_awready", 32'(awready), 1);
      chk("rst_arready", 32'(arready), 1);
      chk("rst_wready", 32'(wready), 0);
      chk("rst_bvalid", 32'(bvalid), 0);
      chk("rst_rvalid", 32'(rvalid), 0);
      chk("rst_rlast", 32'(rlast), 0);
      chk("rst_bresp_bid", {26'd0, bresp, bid}, 0);
      chk("rst_rresp_rid", {26'd0, rresp, rid}, 0);
      chk("rst_rdata", rdata, 0);
      @(posedge aclk); #1; aresetn = 1'b1;
      @(posedge aclk); #1;

      do_write(4'd3, 16'h0010, 8'd3, 2'b01, 32'hA0, 32'h1, 4'hF, 3, 2'd0);
      do_read(4'd5, 16'h0010, 8'd3, 2'b01, 32'hA0, 32'h1, 2'd0);

      do_write(4'd1, 16'h0020, 8'd0, 2'b01, 32'hDEADBEEF, 32'h0, 4'hF, 0, 2'd0);
      do_write(4'd2, 16'h0020, 8'd1, 2'b00, 32'h11, 32'h11, 4'h3, 1, 2'd0);
      do_read(4'd4, 16'h0020, 8'd0, 2'b01, 32'hDEAD0022, 32'h0, 2'd0);

      do_write(4'd1, 16'h0000, 8'd0, 2'b01, 32'h12345678, 32'h0, 4'hF, 0, 2'd0);
      do_write(4'd9, 16'(DEPTH * 4), 8'd0, 2'b01, 32'hCAFEF00D, 32'h0, 4'hF, 0, 2'd3);
      do_read(4'd9, 16'(DEPTH * 4), 8'd0, 2'b01, 32'h0, 32'h0, 2'd3);
      do_read(4'd1, 16'h0000, 8'd0, 2'b01, 32'h12345678, 32'h0, 2'd0);

      push_read(4'd6, 8'd1, 32'hA0, 32'h1, 2'd0);
      rready = 1'b0;
      ar_send(4'd6, 16'h0010, 8'd1, 2'b01);
      n = 0;
      while (!rvalid && n < 50) begin @(posedge aclk); #1; n++; end
      repeat (3) @(posedge aclk);
      #1; rready = 1'b1;
      wait_drain();

      do_write(4'd10, 16'h0010, 8'd3, 2'b10, 32'hF0, 32'h1, 4'hF, 3, 2'd2);
      do_read(4'd5, 16'h0010, 8'd3, 2'b01, 32'hA0, 32'h1, 2'd0);
      do_write(4'd11, 16'h0030, 8'd2, 2'b01, 32'hB0, 32'h1, 4'hF, 1, 2'd2);
      do_read(4'd11, 16'h0030, 8'd2, 2'b01, 32'hB0, 32'h1, 2'd0);
      do_read(4'd12, 16'h0010, 8'd0, 2'b10, 32'h0, 32'h0, 2'd2);

      push_read(4'd7, 8'd3, 32'hA0, 32'h1, 2'd0);
      ar_send(4'd7, 16'h0010, 8'd3, 2'b01);
      n = 0;
      do begin @(posedge aclk); #3; n++; end while (r_q.size() != 2 && n < 100);
      aresetn = 1'b0;
      #1;
      chk("midburst_rst_rvalid", 32'(rvalid), 0);
      chk("midburst_rst_arready", 32'(arready), 1);
      r_q.delete();
      lat_pending = 1'b0;
      repeat (2) @(posedge aclk);
      #1; aresetn = 1'b1;
      @(posedge aclk); #1;
      chk("post_rst_arready", 32'(arready), 1);
      do_read(4'd8, 16'h0010, 8'd0, 2'b01, 32'hA0, 32'h0, 2'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
